pzbcm_arbiter_packet_mux: RTL

PZBCM_ARBITER_PACKET_MUX -- requirements
Module: pzbcm_arbiter_packet_mux

---
 rtl/pzbcm_arbiter_pkg.sv | 14 +
 rtl/pzbcm_arbiter_packet_mux_buffer.sv | 85 ++++++++
 rtl/pzbcm_arbiter_packet_mux.sv | 119 +++++++++++
 3 files changed

// File: rtl/pzbcm_arbiter_pkg.sv
// Shared types for the packet-aware arbiter mux.
//   pzbcm_arbiter_state_e : packet-tracking FSM state (IDLE between packets,
//                           PACKET while a multi-beat packet is in flight)
package pzbcm_arbiter_pkg;

    localparam int unsigned BUFFER_DEPTH = 2;
    localparam int unsigned COUNT_WIDTH  = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        PACKET = 1'b1
    } pzbcm_arbiter_state_e;

endpackage

// File: rtl/pzbcm_arbiter_packet_mux_buffer.sv
// Two-entry output skid buffer holding data+last; head entry drives the outputs.
//   i_clk, i_rst           : clock, asynchronous active-high reset
//   i_push/i_push_data/i_push_last : write side (ignored when no room)
//   i_pop                  : downstream ready (pops head when valid)
//   o_can_push_c           : room for a beat this cycle (combinational)
//   o_valid/o_data/o_last  : registered head entry
module pzbcm_arbiter_packet_mux_buffer
    import pzbcm_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
)(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_push_last,
    input  logic                  i_pop,
    output logic                  o_can_push_c,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last
);

    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic [DATA_WIDTH-1:0]  tail_data_q;
    logic                   tail_last_q;
    logic                   push;
    logic                   pop;

    // A full buffer still accepts when the head leaves in the same cycle.
    assign pop          = i_pop && o_valid;
    assign o_can_push_c = (count_q != COUNT_WIDTH'(BUFFER_DEPTH)) || pop;
    assign push         = i_push && o_can_push_c;

    // Occupancy update.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end else if (pop && !push) begin
            count_d = count_q - COUNT_WIDTH'(1);
        end
    end

    // Storage: head is the output register, tail is the second slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q     <= '0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_last      <= 1'b0;
            tail_data_q <= '0;
            tail_last_q <= 1'b0;
        end else begin
            count_q <= count_d;
            o_valid <= (count_d != '0);
            if (push && pop) begin
                if (count_q == COUNT_WIDTH'(BUFFER_DEPTH)) begin
                    o_data      <= tail_data_q;
                    o_last      <= tail_last_q;
                    tail_data_q <= i_push_data;
                    tail_last_q <= i_push_last;
                end else begin
                    o_data <= i_push_data;
                    o_last <= i_push_last;
                end
            end else if (pop) begin
                if (count_q == COUNT_WIDTH'(BUFFER_DEPTH)) begin
                    o_data <= tail_data_q;
                    o_last <= tail_last_q;
                end
            end else if (push) begin
                if (count_q == '0) begin
                    o_data <= i_push_data;
                    o_last <= i_push_last;
                end else begin
                    tail_data_q <= i_push_data;
                    tail_last_q <= i_push_last;
                end
            end
        end
    end

endmodule

// File: rtl/pzbcm_arbiter_packet_mux.sv
// Packet mux behind an external arbiter: forwards the granted channel's beats
// through a 2-entry buffer, releases the grant on end-of-packet, and flags
// protocol violations of the grant.
//   i_clk, i_rst              : clock, asynchronous active-high reset
//   o_request / i_grant       : request vector out, one-hot grant in
//   o_free                    : per-channel release pulse on last-beat accept
//   i_valid/o_ready/i_last/i_data : upstream per-channel stream
//   o_valid/i_ready/o_last/o_data : downstream stream
//   o_error                   : sticky grant-protocol error
module pzbcm_arbiter_packet_mux
    import pzbcm_arbiter_pkg::*;
#(
    parameter int unsigned REQUESTS   = 2,
    parameter int unsigned DATA_WIDTH = 32
)(
    input  logic                           i_clk,
    input  logic                           i_rst,
    output logic [REQUESTS-1:0]            o_request,
    input  logic [REQUESTS-1:0]            i_grant,
    output logic [REQUESTS-1:0]            o_free,
    input  logic [REQUESTS-1:0]            i_valid,
    output logic [REQUESTS-1:0]            o_ready,
    input  logic [REQUESTS-1:0]            i_last,
    input  logic [REQUESTS*DATA_WIDTH-1:0] i_data,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic                           o_last,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic                           o_error
);

    pzbcm_arbiter_state_e  state_q;
    pzbcm_arbiter_state_e  state_d;
    logic [REQUESTS-1:0]   sel_q;
    logic [REQUESTS-1:0]   sel_d;
    logic                  error_d;
    logic [REQUESTS-1:0]   accept;
    logic                  can_push;
    logic                  push;
    logic                  push_last;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  multi_grant;

    assign o_request = i_valid;

    // Ready only for the granted channel, and never while reset is held.
    assign o_ready   = i_rst ? '0 : (i_grant & {REQUESTS{can_push}});
    assign accept    = i_valid & o_ready;
    assign push      = |accept;
    assign push_last = |(accept & i_last);
    assign o_free    = accept & i_last;

    // x & (x-1) is non-zero exactly when more than one bit is set.
    assign multi_grant = (i_grant & (i_grant - REQUESTS'(1))) != '0;

    // One-hot AND-OR channel select.
    always_comb begin
        push_data = '0;
        for (int i = 0; i < int'(REQUESTS); i++) begin
            push_data = push_data
                      | ({DATA_WIDTH{i_grant[i]}} & i_data[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Packet FSM: next state, latched channel and sticky error.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        error_d = o_error | multi_grant;
        case (state_q)
            IDLE: begin
                if (push && !push_last) begin
                    state_d = PACKET;
                    sel_d   = accept;
                end
            end
            PACKET: begin
                if (i_grant != sel_q) begin
                    error_d = 1'b1;
                end
                if (push && push_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            o_error <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            o_error <= error_d;
        end
    end

    pzbcm_arbiter_packet_mux_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buffer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (push),
        .i_push_data  (push_data),
        .i_push_last  (push_last),
        .i_pop        (i_ready),
        .o_can_push_c (can_push),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_last       (o_last)
    );

endmodule
